// File: rtl/fpga_cfg_pkg.sv
// Shared constants, target codes and parser state encoding for the configuration loader.
package fpga_cfg_pkg;

  localparam int unsigned BRB_W = 750;
  localparam int unsigned BSB_W = 1728;
  localparam int unsigned LB_W  = 80;
  localparam int unsigned IO_W  = 30;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OFF_W  = 16;
  localparam int unsigned NUM_TGT = 7;

  localparam logic [7:0] SYNC = 8'hA5;

  localparam logic [7:0] TGT_BRB    = 8'd0;
  localparam logic [7:0] TGT_BSB    = 8'd1;
  localparam logic [7:0] TGT_LB     = 8'd2;
  localparam logic [7:0] TGT_LEFT   = 8'd3;
  localparam logic [7:0] TGT_RIGHT  = 8'd4;
  localparam logic [7:0] TGT_TOP    = 8'd5;
  localparam logic [7:0] TGT_BOTTOM = 8'd6;
  localparam logic [7:0] TGT_COMMIT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TARGET = 3'd1,
    ST_OFF_HI = 3'd2,
    ST_OFF_LO = 3'd3,
    ST_COUNT  = 3'd4,
    ST_DATA   = 3'd5
  } state_t;

  // True for codes that name a writable select vector.
  function automatic logic tgt_valid(input logic [7:0] t);
    return t <= TGT_BOTTOM;
  endfunction

endpackage

// File: rtl/cfg_byte_writer.sv
// W-bit select register updated one byte at a time at an arbitrary bit offset.
module cfg_byte_writer #(
  parameter int unsigned W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [15:0]   offset,
  input  logic [7:0]    wr_byte,
  output logic [W-1:0]  sel,
  output logic          oor_c
);

  logic [W-1:0] mask_c;
  logic [W-1:0] data_c;

  // Shifting past the top drops out-of-range bits for free.
  assign mask_c = W'(8'hFF) << offset;
  assign data_c = W'(wr_byte) << offset;

  // 17-bit sum so a byte straddling the 16-bit wrap also reads as out of range.
  assign oor_c = (17'(offset) + 17'd7) >= 17'(W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= '0;
    end else if (wr_en) begin
      sel <= (sel & ~mask_c) | data_c;
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Byte-stream packet parser that loads fpga_top's routing, logic and IO select vectors.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BRB_W-1:0]  brbselect,
  output logic [BSB_W-1:0]  bsbselect,
  output logic [LB_W-1:0]   lbselect,
  output logic [IO_W-1:0]   leftioselect,
  output logic [IO_W-1:0]   rightioselect,
  output logic [IO_W-1:0]   topioselect,
  output logic [IO_W-1:0]   bottomioselect,
  output logic              cfg_done,
  output logic              err
);

  state_t      state, state_n;
  logic [7:0]  tgt, tgt_n;
  logic [15:0] offset, offset_n;
  logic [7:0]  cnt, cnt_n;
  logic        wrapped, wrapped_n;
  logic        cfg_done_n;
  logic        err_n;

  logic        accept_c;
  logic [16:0] next_off_c;
  logic [6:0]  wr_en_c;
  logic [7:0]  oor_c;

  assign accept_c   = in_valid && in_ready;
  assign next_off_c = 17'(offset) + 17'd8;
  assign oor_c[7]   = 1'b0;

  // Parser state and latched packet fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tgt      <= '0;
      offset   <= '0;
      cnt      <= '0;
      wrapped  <= 1'b0;
      cfg_done <= 1'b0;
      err      <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_n;
      tgt      <= tgt_n;
      offset   <= offset_n;
      cnt      <= cnt_n;
      wrapped  <= wrapped_n;
      cfg_done <= cfg_done_n;
      err      <= err_n;
      in_ready <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    tgt_n      = tgt;
    offset_n   = offset;
    cnt_n      = cnt;
    wrapped_n  = wrapped;
    cfg_done_n = cfg_done;
    err_n      = err;
    wr_en_c    = '0;

    if (accept_c) begin
      unique case (state)
        ST_IDLE: begin
          if (in_data == SYNC) begin
            state_n = ST_TARGET;
          end else begin
            err_n = 1'b1;
          end
        end
        ST_TARGET: begin
          if (tgt_valid(in_data)) begin
            tgt_n      = in_data;
            cfg_done_n = 1'b0;
            state_n    = ST_OFF_HI;
          end else if (in_data == TGT_COMMIT) begin
            cfg_done_n = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            // Unknown target: keep parsing so the payload is consumed, but never write it.
            tgt_n   = in_data;
            err_n   = 1'b1;
            state_n = ST_OFF_HI;
          end
        end
        ST_OFF_HI: begin
          offset_n[15:8] = in_data;
          wrapped_n      = 1'b0;
          state_n        = ST_OFF_LO;
        end
        ST_OFF_LO: begin
          offset_n[7:0] = in_data;
          state_n       = ST_COUNT;
        end
        ST_COUNT: begin
          cnt_n   = in_data;
          state_n = (in_data == 8'd0) ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          // Once the offset has wrapped every later bit lies beyond every target.
          if (tgt_valid(tgt)) begin
            if (wrapped) begin
              err_n = 1'b1;
            end else begin
              wr_en_c = 7'b1 << tgt[2:0];
              if (oor_c[tgt[2:0]]) begin
                err_n = 1'b1;
              end
            end
          end
          offset_n = next_off_c[15:0];
          if (next_off_c[16]) begin
            wrapped_n = 1'b1;
          end
          cnt_n = cnt - 8'd1;
          if (cnt == 8'd1) begin
            state_n = ST_IDLE;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  cfg_byte_writer #(.W(BRB_W)) u_brb (
    .clk(clk), .rst(rst), .wr_en(wr_en_c[0]), .offset(offset), .wr_byte(in_data),
    .sel(brbselect), .oor_c(oor_c[0])
  );

  cfg_byte_writer #(.W(BSB_W)) u_bsb (
    .clk(clk), .rst(rst), .wr_en(wr_en_c[1]), .offset(offset), .wr_byte(in_data),
    .sel(bsbselect), .oor_c(oor_c[1])
  );

  cfg_byte_writer #(.W(LB_W)) u_lb (
    .clk(clk), .rst(rst), .wr_en(wr_en_c[2]), .offset(offset), .wr_byte(in_data),
    .sel(lbselect), .oor_c(oor_c[2])
  );

  cfg_byte_writer #(.W(IO_W)) u_left (
    .clk(clk), .rst(rst), .wr_en(wr_en_c[3]), .offset(offset), .wr_byte(in_data),
    .sel(leftioselect), .oor_c(oor_c[3])
  );

  cfg_byte_writer #(.W(IO_W)) u_right (
    .clk(clk), .rst(rst), .wr_en(wr_en_c[4]), .offset(offset), .wr_byte(in_data),
    .sel(rightioselect), .oor_c(oor_c[4])
  );

  cfg_byte_writer #(.W(IO_W)) u_top (
    .clk(clk), .rst(rst), .wr_en(wr_en_c[5]), .offset(offset), .wr_byte(in_data),
    .sel(topioselect), .oor_c(oor_c[5])
  );

  cfg_byte_writer #(.W(IO_W)) u_bottom (
    .clk(clk), .rst(rst), .wr_en(wr_en_c[6]), .offset(offset), .wr_byte(in_data),
    .sel(bottomioselect), .oor_c(oor_c[6])
  );

endmodule
